// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes,
// FSM state encodings and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      OCIOSO    = 4'd0,
      BUSCA     = 4'd1,
      DECOD     = 4'd2,
      EXEC_R    = 4'd3,
      ESCR_R    = 4'd4,
      END_CALC  = 4'd5,
      ACESSO_LW = 4'd6,
      ACESSO_SW = 4'd7,
      ESCR_LW   = 4'd8,
      ESCR_I    = 4'd9,
      BRANCH    = 4'd10,
      SALTO     = 4'd11,
      ERRO      = 4'd12
   } estado_t;

   localparam logic [1:0] ULA_SOMA  = 2'd0;
   localparam logic [1:0] ULA_SUB   = 2'd1;
   localparam logic [1:0] ULA_FUNCT = 2'd2;

   localparam logic [1:0] FB_REG    = 2'd0;
   localparam logic [1:0] FB_QUATRO = 2'd1;
   localparam logic [1:0] FB_IMM    = 2'd2;
   localparam logic [1:0] FB_IMM_SH = 2'd3;

   localparam logic [1:0] PC_ULA      = 2'd0;
   localparam logic [1:0] PC_ULASAIDA = 2'd1;
   localparam logic [1:0] PC_SALTO    = 2'd2;

   // States in which the FSM waits on the memory handshake
   function automatic logic is_wait_state(estado_t s);
      return (s == BUSCA) || (s == ACESSO_LW) || (s == ACESSO_SW);
   endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Bundle between the control unit (master) and the shared datapath/memory (slave).
interface control_multiciclo_if #(
   parameter int OP_W = 6
);
   logic [OP_W-1:0] in_instruction;
   logic            mem_pronto;
   logic            PCEsc;
   logic            PCEscCond;
   logic            Desvio_ne;
   logic            IouD;
   logic            LeMem;
   logic            EscMem;
   logic            IREsc;
   logic            MemParaReg;
   logic            RegDst;
   logic            EscReg;
   logic            ULAFonteA;
   logic [1:0]      ULAFonteB;
   logic [1:0]      ULAop;
   logic [1:0]      FontePC;
   logic            erro;
   logic [3:0]      estado;

   modport master (
      input  in_instruction, mem_pronto,
      output PCEsc, PCEscCond, Desvio_ne, IouD, LeMem, EscMem, IREsc,
             MemParaReg, RegDst, EscReg, ULAFonteA, ULAFonteB, ULAop,
             FontePC, erro, estado
   );

   modport slave (
      output in_instruction, mem_pronto,
      input  PCEsc, PCEscCond, Desvio_ne, IouD, LeMem, EscMem, IREsc,
             MemParaReg, RegDst, EscReg, ULAFonteA, ULAFonteB, ULAop,
             FontePC, erro, estado
   );
endinterface

// File: rtl/control_multiciclo_espera_mem.sv
// Memory wait counter: counts cycles spent in a wait state without mem_pronto
// and flags a timeout once MEM_TIMEOUT such cycles have elapsed.
// MEM_TIMEOUT = 0 disables the timeout (waits forever).
module espera_mem #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset_n,
   input  logic em_espera,
   input  logic mem_pronto,
   output logic estouro
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMITE  = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] contador;

   // Count stalled cycles; any cycle outside a wait state or with mem_pronto clears it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         contador <= '0;
      end else if (em_espera && !mem_pronto) begin
         if (contador != CNT_MAX) begin
            contador <= contador + CNT_W'(1);
         end
      end else begin
         contador <= '0;
      end
   end

   assign estouro = (MEM_TIMEOUT != 0) && em_espera && !mem_pronto && (contador == LIMITE);

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM decoding the IR opcode into datapath
// mux selects and enables, with a memory-ready handshake and wait timeout.
module control_multiciclo
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W        = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter bit HAS_BNE     = 1'b1
) (
   input logic                  clock,
   input logic                  reset_n,
   control_multiciclo_if.master bus
);

   estado_t estado_atual;
   estado_t proximo_estado;
   logic    em_espera;
   logic    estouro;

   assign em_espera = is_wait_state(estado_atual);

   espera_mem #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_espera_mem (
      .clock     (clock),
      .reset_n   (reset_n),
      .em_espera (em_espera),
      .mem_pronto(bus.mem_pronto),
      .estouro   (estouro)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_atual <= OCIOSO;
      end else begin
         estado_atual <= proximo_estado;
      end
   end

   // Next-state logic: memory handshake, opcode dispatch and timeout
   always_comb begin
      proximo_estado = estado_atual;
      case (estado_atual)
         OCIOSO: proximo_estado = BUSCA;
         BUSCA: begin
            if (bus.mem_pronto)  proximo_estado = DECOD;
            else if (estouro)    proximo_estado = ERRO;
         end
         DECOD: begin
            if (bus.in_instruction == OP_W'(OP_R))
               proximo_estado = EXEC_R;
            else if ((bus.in_instruction == OP_W'(OP_LW)) ||
                     (bus.in_instruction == OP_W'(OP_SW)) ||
                     (bus.in_instruction == OP_W'(OP_ADDI)))
               proximo_estado = END_CALC;
            else if (bus.in_instruction == OP_W'(OP_BEQ))
               proximo_estado = BRANCH;
            else if (bus.in_instruction == OP_W'(OP_BNE))
               proximo_estado = HAS_BNE ? BRANCH : ERRO;
            else if (bus.in_instruction == OP_W'(OP_J))
               proximo_estado = SALTO;
            else
               proximo_estado = ERRO;
         end
         EXEC_R: proximo_estado = ESCR_R;
         ESCR_R: proximo_estado = BUSCA;
         END_CALC: begin
            if (bus.in_instruction == OP_W'(OP_LW))        proximo_estado = ACESSO_LW;
            else if (bus.in_instruction == OP_W'(OP_SW))   proximo_estado = ACESSO_SW;
            else if (bus.in_instruction == OP_W'(OP_ADDI)) proximo_estado = ESCR_I;
            else                                           proximo_estado = ERRO;
         end
         ACESSO_LW: begin
            if (bus.mem_pronto)  proximo_estado = ESCR_LW;
            else if (estouro)    proximo_estado = ERRO;
         end
         ACESSO_SW: begin
            if (bus.mem_pronto)  proximo_estado = BUSCA;
            else if (estouro)    proximo_estado = ERRO;
         end
         ESCR_LW: proximo_estado = BUSCA;
         ESCR_I:  proximo_estado = BUSCA;
         BRANCH:  proximo_estado = BUSCA;
         SALTO:   proximo_estado = BUSCA;
         ERRO:    proximo_estado = ERRO;
         default: proximo_estado = ERRO;
      endcase
   end

   // Output decode from the registered state; only the fetch strobes see mem_pronto
   always_comb begin
      bus.PCEsc      = 1'b0;
      bus.PCEscCond  = 1'b0;
      bus.Desvio_ne  = 1'b0;
      bus.IouD       = 1'b0;
      bus.LeMem      = 1'b0;
      bus.EscMem     = 1'b0;
      bus.IREsc      = 1'b0;
      bus.MemParaReg = 1'b0;
      bus.RegDst     = 1'b0;
      bus.EscReg     = 1'b0;
      bus.ULAFonteA  = 1'b0;
      bus.ULAFonteB  = FB_REG;
      bus.ULAop      = ULA_SOMA;
      bus.FontePC    = PC_ULA;
      case (estado_atual)
         BUSCA: begin
            bus.LeMem     = 1'b1;
            bus.ULAFonteB = FB_QUATRO;
            bus.IREsc     = bus.mem_pronto;
            bus.PCEsc     = bus.mem_pronto;
         end
         DECOD: begin
            bus.ULAFonteB = FB_IMM_SH;
         end
         EXEC_R: begin
            bus.ULAFonteA = 1'b1;
            bus.ULAop     = ULA_FUNCT;
         end
         ESCR_R: begin
            bus.RegDst = 1'b1;
            bus.EscReg = 1'b1;
         end
         END_CALC: begin
            bus.ULAFonteA = 1'b1;
            bus.ULAFonteB = FB_IMM;
         end
         ACESSO_LW: begin
            bus.LeMem = 1'b1;
            bus.IouD  = 1'b1;
         end
         ACESSO_SW: begin
            bus.EscMem = 1'b1;
            bus.IouD   = 1'b1;
         end
         ESCR_LW: begin
            bus.EscReg     = 1'b1;
            bus.MemParaReg = 1'b1;
         end
         ESCR_I: begin
            bus.EscReg = 1'b1;
         end
         BRANCH: begin
            bus.ULAFonteA = 1'b1;
            bus.ULAop     = ULA_SUB;
            bus.PCEscCond = 1'b1;
            bus.FontePC   = PC_ULASAIDA;
            bus.Desvio_ne = bus.in_instruction[0];
         end
         SALTO: begin
            bus.PCEsc   = 1'b1;
            bus.FontePC = PC_SALTO;
         end
         default: ;
      endcase
   end

   assign bus.erro   = (estado_atual == ERRO);
   assign bus.estado = estado_atual;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed testbench for control_multiciclo: walks every instruction class,
// memory waits, timeout, illegal opcodes and async reset, and compares the
// full output vector against hand-written per-state expectations.
module tb_control_multiciclo;
   import mips_ctrl_pkg::*;

   logic       clock;
   logic       reset_n;
   logic [5:0] instr;
   logic       mem_pronto;
   int         checks;
   int         failures;

   control_multiciclo_if #(.OP_W(6)) bus_a ();
   control_multiciclo_if #(.OP_W(6)) bus_b ();

   assign bus_a.in_instruction = instr;
   assign bus_a.mem_pronto     = mem_pronto;
   assign bus_b.in_instruction = instr;
   assign bus_b.mem_pronto     = mem_pronto;

   control_multiciclo #(.OP_W(6), .MEM_TIMEOUT(15), .HAS_BNE(1'b1)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_a)
   );

   control_multiciclo #(.OP_W(6), .MEM_TIMEOUT(15), .HAS_BNE(1'b0)) dut_nb (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_b)
   );

   logic [21:0] obs_a;
   logic [21:0] obs_b;

   assign obs_a = {bus_a.PCEsc, bus_a.PCEscCond, bus_a.Desvio_ne, bus_a.IouD, bus_a.LeMem,
                   bus_a.EscMem, bus_a.IREsc, bus_a.MemParaReg, bus_a.RegDst, bus_a.EscReg,
                   bus_a.ULAFonteA, bus_a.ULAFonteB, bus_a.ULAop, bus_a.FontePC,
                   bus_a.erro, bus_a.estado};
   assign obs_b = {bus_b.PCEsc, bus_b.PCEscCond, bus_b.Desvio_ne, bus_b.IouD, bus_b.LeMem,
                   bus_b.EscMem, bus_b.IREsc, bus_b.MemParaReg, bus_b.RegDst, bus_b.EscReg,
                   bus_b.ULAFonteA, bus_b.ULAFonteB, bus_b.ULAop, bus_b.FontePC,
                   bus_b.erro, bus_b.estado};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected outputs for each state, taken straight from the state table
   function automatic logic [21:0] exp_vec(estado_t st, logic mp, logic [5:0] op);
      logic       pc_esc = 1'b0, pc_esc_cond = 1'b0, desvio_ne = 1'b0, iou_d = 1'b0;
      logic       le_mem = 1'b0, esc_mem = 1'b0, ir_esc = 1'b0, mem_para_reg = 1'b0;
      logic       reg_dst = 1'b0, esc_reg = 1'b0, fonte_a = 1'b0, erro = 1'b0;
      logic [1:0] fonte_b = 2'd0, ula_op = 2'd0, fonte_pc = 2'd0;
      case (st)
         BUSCA:     begin le_mem = 1'b1; fonte_b = 2'd1; ir_esc = mp; pc_esc = mp; end
         DECOD:     begin fonte_b = 2'd3; end
         EXEC_R:    begin fonte_a = 1'b1; ula_op = 2'd2; end
         ESCR_R:    begin reg_dst = 1'b1; esc_reg = 1'b1; end
         END_CALC:  begin fonte_a = 1'b1; fonte_b = 2'd2; end
         ACESSO_LW: begin le_mem = 1'b1; iou_d = 1'b1; end
         ACESSO_SW: begin esc_mem = 1'b1; iou_d = 1'b1; end
         ESCR_LW:   begin esc_reg = 1'b1; mem_para_reg = 1'b1; end
         ESCR_I:    begin esc_reg = 1'b1; end
         BRANCH:    begin fonte_a = 1'b1; ula_op = 2'd1; pc_esc_cond = 1'b1;
                          fonte_pc = 2'd1; desvio_ne = op[0]; end
         SALTO:     begin pc_esc = 1'b1; fonte_pc = 2'd2; end
         ERRO:      begin erro = 1'b1; end
         default:   ;
      endcase
      return {pc_esc, pc_esc_cond, desvio_ne, iou_d, le_mem, esc_mem, ir_esc, mem_para_reg,
              reg_dst, esc_reg, fonte_a, fonte_b, ula_op, fonte_pc, erro, st};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic mp);
      instr      = op;
      mem_pronto = mp;
   endtask

   task automatic checkOutput(input string tag, input int which, input estado_t st);
      logic [21:0] obs;
      logic [21:0] expv;
      #1;
      obs  = (which == 0) ? obs_a : obs_b;
      expv = exp_vec(st, mem_pronto, instr);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input logic [5:0] op, input logic mp, input estado_t st);
      applyStimulus(op, mp);
      checkOutput(tag, 0, st);
      tick();
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      instr      = 6'b0;
      mem_pronto = 1'b0;
      tick();
      tick();
      $display("[TB] reset and release");
      checkOutput("reset_idle", 0, OCIOSO);
      reset_n = 1'b1;
      checkOutput("ocioso_after_release", 0, OCIOSO);
      tick();

      $display("[TB] R-type");
      step("r_busca", OP_R, 1'b1, BUSCA);
      step("r_decod", OP_R, 1'b1, DECOD);
      step("r_exec",  OP_R, 1'b1, EXEC_R);
      step("r_escr",  OP_R, 1'b1, ESCR_R);

      $display("[TB] lw with three wait cycles");
      step("lw_busca", OP_LW, 1'b1, BUSCA);
      step("lw_decod", OP_LW, 1'b1, DECOD);
      step("lw_end",   OP_LW, 1'b1, END_CALC);
      for (int i = 0; i < 3; i++) step("lw_wait", OP_LW, 1'b0, ACESSO_LW);
      step("lw_ready", OP_LW, 1'b1, ACESSO_LW);
      step("lw_escr",  OP_LW, 1'b1, ESCR_LW);

      $display("[TB] sw");
      step("sw_busca", OP_SW, 1'b1, BUSCA);
      step("sw_decod", OP_SW, 1'b1, DECOD);
      step("sw_end",   OP_SW, 1'b1, END_CALC);
      step("sw_wait",  OP_SW, 1'b0, ACESSO_SW);
      step("sw_ready", OP_SW, 1'b1, ACESSO_SW);

      $display("[TB] addi");
      step("addi_busca", OP_ADDI, 1'b1, BUSCA);
      step("addi_decod", OP_ADDI, 1'b1, DECOD);
      step("addi_end",   OP_ADDI, 1'b1, END_CALC);
      step("addi_escr",  OP_ADDI, 1'b1, ESCR_I);

      $display("[TB] beq");
      step("beq_busca", OP_BEQ, 1'b1, BUSCA);
      step("beq_decod", OP_BEQ, 1'b1, DECOD);
      applyStimulus(OP_BEQ, 1'b1);
      checkOutput("beq_branch", 0, BRANCH);
      checkOutput("beq_branch_nb", 1, BRANCH);
      tick();

      $display("[TB] bne");
      step("bne_busca", OP_BNE, 1'b1, BUSCA);
      step("bne_decod", OP_BNE, 1'b1, DECOD);
      applyStimulus(OP_BNE, 1'b1);
      checkOutput("bne_branch", 0, BRANCH);
      checkOutput("bne_illegal_nb", 1, ERRO);
      tick();

      $display("[TB] j and illegal opcode");
      step("j_busca",    OP_J, 1'b1, BUSCA);
      step("j_decod",    OP_J, 1'b1, DECOD);
      step("j_salto",    OP_J, 1'b1, SALTO);
      step("ill_busca",  6'b111111, 1'b1, BUSCA);
      step("ill_decod",  6'b111111, 1'b1, DECOD);
      step("ill_erro",   OP_R, 1'b1, ERRO);
      step("erro_sticky", OP_R, 1'b1, ERRO);

      $display("[TB] async reset in ACESSO_LW");
      reset_n = 1'b0;
      checkOutput("erro_cleared", 0, OCIOSO);
      reset_n = 1'b1;
      tick();
      step("lw2_busca", OP_LW, 1'b1, BUSCA);
      step("lw2_decod", OP_LW, 1'b1, DECOD);
      step("lw2_end",   OP_LW, 1'b1, END_CALC);
      applyStimulus(OP_LW, 1'b0);
      checkOutput("lw2_wait", 0, ACESSO_LW);
      reset_n = 1'b0;
      checkOutput("async_reset", 0, OCIOSO);
      tick();
      checkOutput("reset_held", 0, OCIOSO);
      reset_n = 1'b1;
      tick();

      $display("[TB] fetch timeout");
      for (int k = 1; k <= 16; k++) step("timeout_wait", OP_R, 1'b0, BUSCA);
      step("timeout_erro",   OP_R, 1'b0, ERRO);
      step("timeout_sticky", OP_R, 1'b1, ERRO);

      $display("[TB] memory ready on the last allowed cycle");
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int k = 1; k <= 15; k++) step("late_wait", OP_R, 1'b0, BUSCA);
      step("late_ready", OP_R, 1'b1, BUSCA);
      step("late_decod", OP_R, 1'b1, DECOD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
